regfile_wb_arbiter: RTL and testbench

- Shares the single write-back path into the general-purpose register bank between several requesters (ALU, load unit, immediate/move unit).
- Arbitrates with round-robin priority and accepts one write per cycle through a valid/ready handshake.
- Drives one registered write: one-hot clock-enables for the bank's per-register ce inputs, plus a shared write-data bus.
- Sits between the execute/load stages and the register bank.

---
 rtl/regfile_pkg.sv | 20 ++
 rtl/regfile_wb_arbiter_rr_arbiter.sv | 52 +++++
 rtl/regfile_wb_arbiter.sv | 85 ++++++++
 tb/tb_regfile_wb_arbiter.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the register-bank write-back path.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package regfile_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int NREGS_DEF = 8;
  localparam int MAX_REGS  = 16;

  // One-hot decode of a register address; out-of-range addresses give all zeros
  // so a bad write never touches the bank.
  function automatic logic [MAX_REGS-1:0] onehot_dec(input logic [3:0] addr,
                                                     input logic [4:0] n);
    logic [MAX_REGS-1:0] res;
    res = '0;
    if ({1'b0, addr} < n) res[addr] = 1'b1;
    return res;
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// Round-robin priority search over NREQ requesters with a rotating pointer.
// Latency: grant is combinational in the request cycle; pointer updates on the edge.
// Backpressure: en=0 suppresses all grants and freezes the pointer.
module rr_arbiter #(
  parameter  int NREQ = 3,
  localparam int IW   = $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic            en,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   gnt_idx
);

  logic [IW-1:0] ptr_q;
  logic [IW-1:0] ptr_d;
  logic          found;

  // Scan upward from the pointer with wrap-around; first valid requester wins.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      int j;
      j = int'(ptr_q) + k;
      if (j >= NREQ) j = j - NREQ;
      if (!found && req[j]) begin
        found   = 1'b1;
        gnt_idx = IW'(j);
      end
    end
    if (en && found) gnt[gnt_idx] = 1'b1;
  end

  // Next pointer: one past the granted requester, wrapping at NREQ.
  always_comb begin
    ptr_d = ptr_q;
    if (|gnt) begin
      if (gnt_idx == IW'(NREQ - 1)) ptr_d = '0;
      else                          ptr_d = gnt_idx + 1'b1;
    end
  end

  // Pointer register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-bank write-back port among NREQ requesters, round-robin.
// Latency: write accepted in cycle N drives reg_ce/reg_wdata during cycle N+1.
// Backpressure: hold=1 or no valid request -> req_ready all 0; issued writes still drain.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int NREQ  = 3,
  parameter int NREGS = NREGS_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          hold,
  input  logic [NREQ-1:0]               req_valid,
  input  logic [NREQ*$clog2(NREGS)-1:0] req_addr,
  input  logic [NREQ*WIDTH-1:0]         req_data,
  output logic [NREQ-1:0]               req_ready,
  output logic [NREGS-1:0]              reg_ce,
  output logic [WIDTH-1:0]              reg_wdata,
  output logic [$clog2(NREQ)-1:0]       last_grant,
  output logic                          addr_err
);

  localparam int AW = $clog2(NREGS);
  localparam int IW = $clog2(NREQ);

  logic [NREQ-1:0]  gnt;
  logic [IW-1:0]    gnt_idx;
  logic             accept;
  logic [AW-1:0]    sel_addr;
  logic [WIDTH-1:0] sel_data;
  logic [3:0]       addr_ext;
  logic             oob;

  logic [NREGS-1:0] reg_ce_q, reg_ce_d;
  logic [WIDTH-1:0] reg_wdata_q;
  logic [IW-1:0]    last_grant_q;
  logic             addr_err_q;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (req_valid),
    .en      (~hold),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  // A grant is only ever raised for a valid requester, so grant == accept.
  assign req_ready = gnt;
  assign accept    = |gnt;

  // Select the winner's address/data and decode the target register.
  always_comb begin
    sel_addr = req_addr[int'(gnt_idx)*AW +: AW];
    sel_data = req_data[int'(gnt_idx)*WIDTH +: WIDTH];
    addr_ext = 4'(sel_addr);
    oob      = ({1'b0, addr_ext} >= 5'(NREGS));
    reg_ce_d = '0;
    if (accept) reg_ce_d = NREGS'(onehot_dec(addr_ext, 5'(NREGS)));
  end

  // Output registers; reset also discards a write accepted but not yet issued.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reg_ce_q     <= '0;
      reg_wdata_q  <= '0;
      last_grant_q <= '0;
      addr_err_q   <= 1'b0;
    end else begin
      reg_ce_q <= reg_ce_d;
      if (accept) begin
        reg_wdata_q  <= sel_data;
        last_grant_q <= gnt_idx;
        if (oob) addr_err_q <= 1'b1;
      end
    end
  end

  assign reg_ce     = reg_ce_q;
  assign reg_wdata  = reg_wdata_q;
  assign last_grant = last_grant_q;
  assign addr_err   = addr_err_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter with a six-register bank.
// Latency: expected issue records are queued at accept, popped one edge later.
// Backpressure: hold and idle cycles queue an all-zero reg_ce record.
module tb_regfile_wb_arbiter;

  localparam int WIDTH = 8;
  localparam int NREQ  = 3;
  localparam int NREGS = 6;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        hold = 1'b0;
  logic [2:0]  req_valid = '0;
  logic [8:0]  req_addr = '0;
  logic [23:0] req_data = '0;
  logic [2:0]  req_ready;
  logic [5:0]  reg_ce;
  logic [7:0]  reg_wdata;
  logic [1:0]  last_grant;
  logic        addr_err;

  regfile_wb_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .NREGS(NREGS)) dut (
    .clk        (clk),
    .rst        (rst),
    .hold       (hold),
    .req_valid  (req_valid),
    .req_addr   (req_addr),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .reg_ce     (reg_ce),
    .reg_wdata  (reg_wdata),
    .last_grant (last_grant),
    .addr_err   (addr_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0] ce;
    logic [7:0] wd;
    logic [1:0] lg;
    logic       err;
  } exp_t;

  exp_t       sb[$];
  int         checks = 0;
  int         errors = 0;
  logic [7:0] mdl_wd = '0;
  logic [1:0] mdl_lg = '0;
  logic       mdl_err = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " reg_ce"},     32'(reg_ce),     32'd0);
    chk({tag, " reg_wdata"},  32'(reg_wdata),  32'd0);
    chk({tag, " last_grant"}, 32'(last_grant), 32'd0);
    chk({tag, " addr_err"},   32'(addr_err),   32'd0);
  endtask

  // Drive one cycle of requests, check the combinational grant, queue the issue.
  task automatic drive(input logic h, input logic [2:0] v,
                       input logic [2:0] a0, input logic [2:0] a1, input logic [2:0] a2,
                       input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2,
                       input logic [2:0] exp_rdy, input string tag);
    exp_t       e;
    logic [2:0] a;
    logic [7:0] d;
    logic [1:0] idx;
    @(negedge clk);
    hold      = h;
    req_valid = v;
    req_addr  = {a2, a1, a0};
    req_data  = {d2, d1, d0};
    #1;
    chk({tag, " req_ready"}, 32'(req_ready), 32'(exp_rdy));
    e.ce = '0;
    if (exp_rdy != 3'b000) begin
      case (exp_rdy)
        3'b001:  begin idx = 2'd0; a = a0; d = d0; end
        3'b010:  begin idx = 2'd1; a = a1; d = d1; end
        default: begin idx = 2'd2; a = a2; d = d2; end
      endcase
      e.ce   = (a < 3'(NREGS)) ? 6'(1 << a) : 6'd0;
      mdl_wd = d;
      mdl_lg = idx;
      if (a >= 3'(NREGS)) mdl_err = 1'b1;
    end
    e.wd  = mdl_wd;
    e.lg  = mdl_lg;
    e.err = mdl_err;
    sb.push_back(e);
  endtask

  // After the edge, pop the oldest expected issue and compare the registered outputs.
  task automatic tick(input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s: scoreboard empty, observed reg_ce 0x%0h expected queued record", tag, reg_ce);
    end else begin
      e = sb.pop_front();
      chk({tag, " reg_ce"},     32'(reg_ce),     32'(e.ce));
      chk({tag, " reg_wdata"},  32'(reg_wdata),  32'(e.wd));
      chk({tag, " last_grant"}, 32'(last_grant), 32'(e.lg));
      chk({tag, " addr_err"},   32'(addr_err),   32'(e.err));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] fair_exp[6];
    fair_exp = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};

    // Async reset pulse mid-cycle: outputs clear without a clock edge.
    #3 rst = 1'b1;
    #1 chk_zero("async_reset");
    @(negedge clk) rst = 1'b0;

    // Idle cycles.
    repeat (5) begin
      drive(1'b0, 3'b000, 3'd0, 3'd0, 3'd0, 8'h00, 8'h00, 8'h00, 3'b000, "idle");
      tick("idle");
    end

    // Pointer still at 0 after idle: with all valid, requester 0 wins.
    drive(1'b0, 3'b111, 3'd1, 3'd2, 3'd3, 8'h11, 8'h22, 8'h33, 3'b001, "ptr0");
    tick("ptr0");

    // Single write from requester 0.
    drive(1'b0, 3'b001, 3'd3, 3'd0, 3'd0, 8'hA5, 8'h00, 8'h00, 3'b001, "single");
    tick("single");

    // Highest valid register index, pointer wraps back to 0.
    drive(1'b0, 3'b100, 3'd0, 3'd0, 3'd5, 8'h00, 8'h00, 8'h5A, 3'b100, "top_reg");
    tick("top_reg");

    // Fairness: all three valid for six back-to-back cycles.
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 3'b111, 3'd1, 3'd2, 3'd3, 8'h11, 8'h22, 8'h33, fair_exp[i], "fair");
      tick("fair");
    end

    // Hold: grant req2, then freeze two cycles; req2's issue still drains.
    drive(1'b0, 3'b100, 3'd0, 3'd0, 3'd4, 8'h00, 8'h00, 8'h44, 3'b100, "pre_hold");
    tick("pre_hold");
    repeat (2) begin
      drive(1'b1, 3'b101, 3'd0, 3'd0, 3'd4, 8'h0F, 8'h00, 8'h44, 3'b000, "hold");
      tick("hold");
    end
    drive(1'b0, 3'b101, 3'd0, 3'd0, 3'd4, 8'h0F, 8'h00, 8'h44, 3'b001, "release");
    tick("release");

    // Out-of-range address: handshake completes, no register written, sticky error.
    drive(1'b0, 3'b010, 3'd0, 3'd7, 3'd0, 8'h00, 8'h77, 8'h00, 3'b010, "addr_err");
    tick("addr_err");
    drive(1'b0, 3'b100, 3'd0, 3'd0, 3'd2, 8'h00, 8'h00, 8'h22, 3'b100, "after_err");
    tick("after_err");

    // Reset between accept and issue: the write is dropped.
    drive(1'b0, 3'b010, 3'd0, 3'd4, 3'd0, 8'h00, 8'h99, 8'h00, 3'b010, "rst_mid");
    #2 rst = 1'b1;
    sb.delete();
    mdl_wd  = '0;
    mdl_lg  = '0;
    mdl_err = 1'b0;
    #1 chk_zero("rst_mid_async");
    @(posedge clk);
    #1 chk("rst_mid_edge reg_ce", 32'(reg_ce), 32'd0);
    @(negedge clk);
    rst       = 1'b0;
    req_valid = 3'b000;
    @(posedge clk);
    #1 chk("rst_release reg_ce", 32'(reg_ce), 32'd0);

    // Pointer back at 0: req1 beats req2.
    drive(1'b0, 3'b110, 3'd0, 3'd1, 3'd2, 8'h00, 8'hB1, 8'hC2, 3'b010, "post_rst");
    tick("post_rst");
    drive(1'b0, 3'b100, 3'd0, 3'd1, 3'd2, 8'h00, 8'hB1, 8'hC2, 3'b100, "post_rst2");
    tick("post_rst2");
    drive(1'b0, 3'b000, 3'd0, 3'd0, 3'd0, 8'h00, 8'h00, 8'h00, 3'b000, "final_idle");
    tick("final_idle");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
